// File: rtl/ysyx_23060208_isram_if.sv
// rtl/ysyx_23060208_isram_if.sv - IFU fetch bus between the fetch unit and the instruction SRAM
interface ysyx_23060208_isram_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] isram_raddr;
    logic [DATA_WIDTH-1:0] isram_rdata;
    logic                  isram_ready;
    logic                  isram_err;

    modport master (
        output isram_raddr,
        input  isram_rdata,
        input  isram_ready,
        input  isram_err
    );

    modport slave (
        input  isram_raddr,
        output isram_rdata,
        output isram_ready,
        output isram_err
    );
endinterface

// File: rtl/ysyx_23060208_isram.sv
// rtl/ysyx_23060208_isram.sv - instruction SRAM responder with programmable latency and LFSR jitter
module ysyx_23060208_isram #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 1,
    parameter bit          RAND_DELAY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_23060208_isram_if.slave  fetch,
    output logic                  busy,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [4:0]            cnt;
    logic [3:0]            lfsr;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Word offset from the base; wraps modulo 2^32 so addresses below the base land out of range.
    logic [DATA_WIDTH-3:0] word_off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err_now;
    logic [4:0]            jitter;
    logic [4:0]            delay;

    assign word_off     = fetch.isram_raddr[DATA_WIDTH-1:2] - BASE_ADDR[DATA_WIDTH-1:2];
    assign idx          = word_off[ADDR_WIDTH-1:0];
    assign misaligned   = (fetch.isram_raddr[1:0] != 2'b00);
    assign out_of_range = (word_off[DATA_WIDTH-3:ADDR_WIDTH] != '0);
    assign err_now      = misaligned | out_of_range;
    assign jitter       = RAND_DELAY ? {3'b000, lfsr[1:0]} : 5'd0;
    assign delay        = 5'(LATENCY) + jitter;

    // Preload port; non-blocking write gives read-before-write against a same-cycle accept.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            lfsr      <= 4'b1001;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            if (state == WAIT) begin
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state <= RESP;
                end
            end else begin
                // IDLE and RESP both accept, so back-to-back fetches have no bubble.
                resp_data <= err_now ? '0 : mem[idx];
                resp_err  <= err_now;
                cnt       <= delay - 5'd1;
                state     <= (delay == 5'd1) ? RESP : WAIT;
            end
        end
    end

    assign fetch.isram_ready = (state == RESP);
    assign fetch.isram_rdata = resp_data;
    assign fetch.isram_err   = (state == RESP) & resp_err;
    assign busy              = (state == WAIT);
endmodule

// File: tb/tb_ysyx_23060208_isram.sv
// tb/tb_ysyx_23060208_isram.sv - table and scoreboard bench for the instruction SRAM responder
module tb_ysyx_23060208_isram;
    typedef struct {
        logic [31:0] raddr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1 = 1'b1;
    logic        rst3 = 1'b1;
    logic        rstj = 1'b1;
    logic        rst4 = 1'b1;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        busy1, busy3, busyj, busy4;

    longint      cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [3:0]  refj;
    logic [31:0] shadow [0:1023];
    exp_t        sb [4][$];

    logic [3:0]  rdy;
    logic [3:0]  er;
    logic [3:0]  bz;
    logic [31:0] rd [4];

    ysyx_23060208_isram_if #(.DATA_WIDTH(32)) f1 ();
    ysyx_23060208_isram_if #(.DATA_WIDTH(32)) f3 ();
    ysyx_23060208_isram_if #(.DATA_WIDTH(32)) fj ();
    ysyx_23060208_isram_if #(.DATA_WIDTH(32)) f4 ();

    ysyx_23060208_isram #(.LATENCY(1), .RAND_DELAY(1'b0)) u1 (
        .clk(clk), .rst(rst1), .fetch(f1), .busy(busy1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ysyx_23060208_isram #(.LATENCY(3), .RAND_DELAY(1'b0)) u3 (
        .clk(clk), .rst(rst3), .fetch(f3), .busy(busy3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ysyx_23060208_isram #(.LATENCY(2), .RAND_DELAY(1'b1)) uj (
        .clk(clk), .rst(rstj), .fetch(fj), .busy(busyj),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    ysyx_23060208_isram #(.LATENCY(4), .RAND_DELAY(1'b0)) u4 (
        .clk(clk), .rst(rst4), .fetch(f4), .busy(busy4),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    assign rdy = {f4.isram_ready, fj.isram_ready, f3.isram_ready, f1.isram_ready};
    assign er  = {f4.isram_err, fj.isram_err, f3.isram_err, f1.isram_err};
    assign bz  = {busy4, busyj, busy3, busy1};
    assign rd[0] = f1.isram_rdata;
    assign rd[1] = f3.isram_rdata;
    assign rd[2] = fj.isram_rdata;
    assign rd[3] = f4.isram_rdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        refj <= rstj ? 4'b1001 : {refj[2:0], refj[3] ^ refj[2]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int k, input logic [31:0] d, input logic e, input longint due);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.due  = due;
        sb[k].push_back(x);
    endtask

    task automatic monitor();
        exp_t x;
        for (int k = 0; k < 4; k++) begin
            if (rdy[k]) begin
                if (sb[k].size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_ready dut%0d: ready=1 want 0 (cycle %0d)", k, cyc);
                end else begin
                    x = sb[k].pop_front();
                    chk($sformatf("ready_cycle dut%0d", k), 32'(cyc), 32'(x.due));
                    chk($sformatf("rdata dut%0d", k), rd[k], x.data);
                    chk($sformatf("err dut%0d", k), {31'b0, er[k]}, {31'b0, x.err});
                end
            end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
                x = sb[k].pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL missing_ready dut%0d: ready=0 want 1 (due cycle %0d, now %0d)", k, x.due, cyc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a >= 32'h8000_1000);
    endfunction

    initial begin
        vec_t        vecs [7];
        int          d;
        int          w;
        logic [31:0] a;
        logic [31:0] old5;

        f1.isram_raddr = '0;
        f3.isram_raddr = '0;
        fj.isram_raddr = '0;
        f4.isram_raddr = '0;

        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h0000_0513, 1'b0};
        vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_1000, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{32'h8000_0010, 32'h0000_0813, 1'b0};

        @(posedge clk);
        #1;
        // Preload while every instance is held in reset.
        for (int i = 0; i < 17; i++) begin
            w = (i == 16) ? 1023 : i;
            ld_en   = 1'b1;
            ld_addr = 10'(w);
            ld_data = (i == 16) ? 32'hDEAD_BEEF : 32'h0000_0413 + 32'(i) * 32'h100;
            shadow[w] = ld_data;
            tick();
        end
        ld_en = 1'b0;

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_ready dut%0d", k), {31'b0, rdy[k]}, 32'h0);
            chk($sformatf("reset_err dut%0d", k), {31'b0, er[k]}, 32'h0);
            chk($sformatf("reset_busy dut%0d", k), {31'b0, bz[k]}, 32'h0);
            chk($sformatf("reset_rdata dut%0d", k), rd[k], 32'h0);
        end

        // LATENCY=1: one accept per cycle from the vector table.
        rst1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            f1.isram_raddr = vecs[i].raddr;
            push_exp(0, vecs[i].data, vecs[i].err, cyc + 1);
            tick();
        end
        // Same-cycle load to word 5 must not affect the access being accepted.
        old5 = shadow[5];
        f1.isram_raddr = 32'h8000_0014;
        ld_en = 1'b1;
        ld_addr = 10'd5;
        ld_data = 32'hCAFE_0005;
        push_exp(0, old5, 1'b0, cyc + 1);
        shadow[5] = 32'hCAFE_0005;
        tick();
        ld_en = 1'b0;
        push_exp(0, shadow[5], 1'b0, cyc + 1);
        tick();
        rst1 = 1'b1;
        tick();

        // LATENCY=3: busy for two cycles, address changes during WAIT ignored.
        rst3 = 1'b0;
        f3.isram_raddr = 32'h8000_0008;
        push_exp(1, shadow[2], 1'b0, cyc + 3);
        tick();
        f3.isram_raddr = 32'h8000_000C;
        chk("lat3_busy_t1", {31'b0, busy3}, 32'h1);
        chk("lat3_ready_t1", {31'b0, f3.isram_ready}, 32'h0);
        tick();
        chk("lat3_busy_t2", {31'b0, busy3}, 32'h1);
        tick();
        chk("lat3_busy_t3", {31'b0, busy3}, 32'h0);
        chk("lat3_ready_t3", {31'b0, f3.isram_ready}, 32'h1);
        f3.isram_raddr = 32'h8000_0000;
        push_exp(1, shadow[0], 1'b0, cyc + 3);
        tick();
        f3.isram_raddr = 32'h8000_0002;
        chk("lat3_err_quiet", {31'b0, f3.isram_err}, 32'h0);
        tick();
        tick();
        rst3 = 1'b1;
        tick();

        // LATENCY=2 with jitter: delay follows the reference LFSR at each accept.
        rstj = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = $urandom_range(0, 15);
            a = (w == 15) ? 32'h8000_0001 : 32'h8000_0000 + 32'(w) * 4;
            fj.isram_raddr = a;
            d = 2 + int'(refj[1:0]);
            push_exp(2, addr_err(a) ? 32'h0 : shadow[w], addr_err(a), cyc + longint'(d));
            repeat (d) tick();
        end
        rstj = 1'b1;
        tick();

        // LATENCY=4: reset two cycles into an access abandons it.
        rst4 = 1'b0;
        f4.isram_raddr = 32'h8000_000C;
        tick();
        chk("rst_mid_busy", {31'b0, busy4}, 32'h1);
        tick();
        rst4 = 1'b1;
        tick();
        chk("rst_mid_ready_t3", {31'b0, f4.isram_ready}, 32'h0);
        chk("rst_mid_busy_t3", {31'b0, busy4}, 32'h0);
        tick();
        rst4 = 1'b0;
        chk("rst_mid_ready_t4", {31'b0, f4.isram_ready}, 32'h0);
        chk("rst_mid_err_t4", {31'b0, f4.isram_err}, 32'h0);
        chk("rst_mid_rdata_t4", f4.isram_rdata, 32'h0);
        chk("rst_mid_busy_t4", {31'b0, busy4}, 32'h0);
        push_exp(3, shadow[3], 1'b0, cyc + 4);
        repeat (4) tick();
        rst4 = 1'b1;
        tick();

        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue_drained dut%0d", k), 32'(sb[k].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ysyx_23060208_isram.md
# ysyx_23060208_isram

Instruction-SRAM responder that sits on the fetch side of the NPC, opposite the IFU. It serves the IFU's `isram_raddr`/`isram_rdata`/`isram_ready` interface. It samples a fetch address, waits a programmable access latency (optionally with pseudo-random jitter), then returns the instruction word with a one-cycle `isram_ready` strobe. A bench-side load port preloads the word array.

## Interface
- `DATA_WIDTH`, 32, instruction/data word width
- `ADDR_WIDTH`, 10, word-index width; array depth = 2^ADDR_WIDTH words
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0
- `LATENCY`, 1, base access latency in cycles, legal 1..15
- `RAND_DELAY`, 0, 1 = add 0..3 cycles of LFSR jitter per access
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `isram_raddr`  in  DATA_WIDTH  fetch byte address from IFU
- `isram_rdata`  out  DATA_WIDTH  instruction word, valid while `isram_ready`=1
- `isram_ready`  out  1  one-cycle response strobe
- `isram_err`  out  1  response is an error (misaligned or out of range); only meaningful with `isram_ready`
- `busy`  out  1  access in flight (state WAIT)
- `ld_en`  in  1  preload write enable
- `ld_addr`  in  ADDR_WIDTH  preload word index
- `ld_data`  in  DATA_WIDTH  preload word

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- Accept cycle: any cycle in IDLE or RESP with `rst`=0. `isram_raddr` is sampled, and the word is read from the array into a response register. An error flag is computed.
- Error: `raddr[1:0]`≠0, or `raddr` outside [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH). The response data is 32'h0 and `isram_err`=1.
- Word index = (raddr − BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits. The subtraction is modulo 2^32.
- Delay D = LATENCY + J, where J = `lfsr[1:0]` at the accept cycle if RAND_DELAY=1, else 0. A counter is loaded with D−1.
- D=1: next state is RESP directly. Otherwise next state is WAIT, which decrements the counter each cycle and goes to RESP when the counter reaches 1.
- RESP: `isram_ready`=1 and `isram_rdata`/`isram_err` are driven from the response register. RESP is also an accept cycle, so back-to-back accesses have no bubble.
- LFSR: 4-bit, taps x^4+x^3+1, seed 4'b1001 on reset. It advances every non-reset cycle regardless of state.
- Preload: when `ld_en`=1, `ld_data` is written to `ld_addr` at the clock edge. The write is allowed in any state.
- Array contents are not cleared by `rst`.

## Timing
- Reset values: `isram_ready`=0, `isram_err`=0, `isram_rdata`=0, `busy`=0, state IDLE, counter 0.
- Accept at cycle t → `isram_ready`=1 in cycle t+D. With LATENCY=1 and no jitter, `isram_ready` stays 1 continuously and the addresses pipeline one per cycle.
- Outside RESP, `isram_rdata` holds the last response value; it is only guaranteed during `isram_ready`. `isram_err` is 0 outside RESP.
- `busy`=1 exactly in WAIT cycles.
- Read-before-write: a load to the same word in the accept cycle returns the old data. Loads after the accept cycle never alter an in-flight response.
- Address changes on `isram_raddr` during WAIT are ignored; only the accept-cycle value is used.
- `rst` mid-access (WAIT or RESP): the access is abandoned and no `isram_ready` is produced. The next cycle is IDLE with outputs at reset values, and the first post-reset accept is the cycle after `rst` falls.
- Maximum D = 18; the counter is 5 bits wide.

## Test plan
- **Preload and basic read:** preload word 0 = 32'h0000_0413 and word 1 = 32'h0000_0513. LATENCY=1, `raddr`=32'h8000_0000 then 32'h8000_0004 → `isram_ready` high in cycles 1 and 2 with rdata 0x413 then 0x513, `isram_err`=0.
- **Multi-cycle latency:** LATENCY=3, accept 32'h8000_0008 at t → `busy`=1 at t+1 and t+2, `isram_ready`=1 only at t+3 with word 2. Changing `raddr` at t+1 has no effect on the returned word.
- **Errors:** `raddr`=32'h8000_0002 → ready with rdata 0, `isram_err`=1. `raddr`=32'h8000_1000 (ADDR_WIDTH=10) → `isram_err`=1. `raddr`=32'h7FFF_FFFC → `isram_err`=1.
- **Jitter:** RAND_DELAY=1, LATENCY=2, 16 consecutive accesses → each ready delay is 2 + `lfsr[1:0]` at its accept cycle, matching a reference LFSR model; all delays fall in 2..5.
- **Reset mid-access:** LATENCY=4, assert `rst` at t+2 after an accept at t → no `isram_ready` at t+4, all outputs 0. Previously preloaded words are still readable after reset.
- **Write collision:** `ld_en` to word 5 in the same cycle as accepting 32'h8000_0014 → the response carries the old word 5. A second read of word 5 returns the new value.
